// File: rtl/reg_wport_sched_pkg.sv
// Shared constants and types for the register-file write-port scheduler.
// Contents: register address/data widths, register count, the r0 constant,
// the default starvation limit, and the write-request payload struct.
package reg_wport_sched_pkg;

  localparam int unsigned ADDR_W         = 5;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned NREG           = 1 << ADDR_W;
  localparam int unsigned STARVE_W       = 4;
  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = '0;

  // One request for the register-file write port.
  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wr_req_t;

endpackage

// File: rtl/reg_wport_sched_if.sv
// Bundle of every scheduler signal except clk/rst.
// master: the surrounding pipeline (WB, long unit, ID, register file).
// slave : the scheduler itself.
interface reg_wport_sched_if
  import reg_wport_sched_pkg::*;
();

  // WB stage
  logic                 wb_we;
  reg_addr_t            wb_waddr;
  reg_data_t            wb_wdata;
  logic                 wb_hold;
  logic                 err_sticky;
  // long-latency unit
  logic                 lu_valid;
  reg_addr_t            lu_waddr;
  reg_data_t            lu_wdata;
  logic                 lu_ready;
  // ID stage
  logic                 is_valid;
  logic                 is_long;
  reg_addr_t            is_rs;
  logic                 is_rs_re;
  reg_addr_t            is_rt;
  logic                 is_rt_re;
  reg_addr_t            is_rd;
  logic                 is_rd_we;
  logic                 is_stall;
  // register file write port and scoreboard view
  logic                 rf_we;
  reg_addr_t            rf_waddr;
  reg_data_t            rf_wdata;
  logic [NREG-1:0]      busy_vec;

  modport master (
    output wb_we, wb_waddr, wb_wdata,
    output lu_valid, lu_waddr, lu_wdata,
    output is_valid, is_long, is_rs, is_rs_re, is_rt, is_rt_re, is_rd, is_rd_we,
    input  lu_ready, is_stall, wb_hold, rf_we, rf_waddr, rf_wdata, busy_vec, err_sticky
  );

  modport slave (
    input  wb_we, wb_waddr, wb_wdata,
    input  lu_valid, lu_waddr, lu_wdata,
    input  is_valid, is_long, is_rs, is_rs_re, is_rt, is_rt_re, is_rd, is_rd_we,
    output lu_ready, is_stall, wb_hold, rf_we, rf_waddr, rf_wdata, busy_vec, err_sticky
  );

endinterface

// File: rtl/reg_wport_sched_scoreboard.sv
// Busy-bit scoreboard for registers with an outstanding long-latency write.
// Ports: clk, rst (sync, active-low); set_en/set_addr mark a register busy;
// clr_en/clr_addr release one; rs/rt/rd_addr are looked up against the
// current (pre-edge) busy state into rs/rt/rd_busy; busy_vec exposes all bits.
module reg_wport_sched_scoreboard
  import reg_wport_sched_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  reg_addr_t       set_addr,
  input  logic            clr_en,
  input  reg_addr_t       clr_addr,
  input  reg_addr_t       rs_addr,
  input  reg_addr_t       rt_addr,
  input  reg_addr_t       rd_addr,
  output logic [NREG-1:0] busy_vec,
  output logic            rs_busy,
  output logic            rt_busy,
  output logic            rd_busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_nxt;

  // Clear and set land together; distinct registers both take effect.
  always_comb begin
    busy_nxt = busy_q;
    if (clr_en) busy_nxt[clr_addr] = 1'b0;
    if (set_en) busy_nxt[set_addr] = 1'b1;
    busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_nxt;
  end

  // Lookups see only the registered state: a same-cycle clear does not release.
  assign rs_busy  = busy_q[rs_addr];
  assign rt_busy  = busy_q[rt_addr];
  assign rd_busy  = busy_q[rd_addr];
  assign busy_vec = busy_q;

endmodule

// File: rtl/reg_wport_sched.sv
// Write-port scheduler: shares the single register-file write port between
// the WB stage (always wins) and a long-latency unit (valid/ready), forces a
// WB bubble after STARVE_MAX consecutive blocked long-unit cycles, and stalls
// ID on RAW/WAW hazards against outstanding long writes.
// Ports: clk, rst (sync, active-low), bus (slave side of reg_wport_sched_if).
// STARVE_MAX must lie in 1..15.
module reg_wport_sched
  import reg_wport_sched_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
)(
  input  logic               clk,
  input  logic               rst,
  reg_wport_sched_if.slave   bus
);

  wr_req_t               grant;
  logic                  port_req;
  logic                  lu_hs;
  logic                  stall;
  logic                  issue_set;
  logic                  rs_busy;
  logic                  rt_busy;
  logic                  rd_busy;
  logic [STARVE_W-1:0]   starve_cnt;
  logic [STARVE_W-1:0]   starve_inc;
  logic                  wb_hold_q;
  logic                  err_q;

  // Port arbitration; reset suppresses the write and the handshake.
  always_comb begin
    grant    = '0;
    port_req = 1'b0;
    lu_hs    = 1'b0;
    if (bus.wb_we) begin
      port_req = 1'b1;
      grant    = '{addr: bus.wb_waddr, data: bus.wb_wdata};
    end else if (bus.lu_valid) begin
      port_req = 1'b1;
      lu_hs    = 1'b1;
      grant    = '{addr: bus.lu_waddr, data: bus.lu_wdata};
    end
    if (!rst) begin
      port_req = 1'b0;
      lu_hs    = 1'b0;
    end
  end

  // r0 writes still complete the handshake but never reach the register file.
  assign bus.rf_we    = port_req && (grant.addr != REG_ZERO);
  assign bus.rf_waddr = grant.addr;
  assign bus.rf_wdata = grant.data;
  assign bus.lu_ready = lu_hs;

  // Hazard stall; a long op also waits while the long unit is still blocked.
  always_comb begin
    stall = bus.is_valid && ((bus.is_rs_re && rs_busy) ||
                             (bus.is_rt_re && rt_busy) ||
                             (bus.is_rd_we && rd_busy) ||
                             (bus.is_long && bus.lu_valid && !lu_hs));
    if (!rst) stall = 1'b1;
  end

  assign bus.is_stall = stall;
  assign issue_set    = bus.is_valid && bus.is_long && bus.is_rd_we && !stall &&
                        (bus.is_rd != REG_ZERO);

  reg_wport_sched_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue_set),
    .set_addr (bus.is_rd),
    .clr_en   (lu_hs),
    .clr_addr (bus.lu_waddr),
    .rs_addr  (bus.is_rs),
    .rt_addr  (bus.is_rt),
    .rd_addr  (bus.is_rd),
    .busy_vec (bus.busy_vec),
    .rs_busy  (rs_busy),
    .rt_busy  (rt_busy),
    .rd_busy  (rd_busy)
  );

  assign starve_inc = starve_cnt + STARVE_W'(1);

  // Starvation counter: the cycle it would reach the limit it wraps to zero
  // and raises wb_hold for exactly the following cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
      wb_hold_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wb_hold_q <= 1'b0;
      if (bus.lu_valid && !lu_hs) begin
        if (starve_inc == STARVE_W'(STARVE_MAX)) begin
          starve_cnt <= '0;
          wb_hold_q  <= 1'b1;
        end else begin
          starve_cnt <= starve_inc;
        end
      end else begin
        starve_cnt <= '0;
      end
      if (wb_hold_q && bus.wb_we) err_q <= 1'b1;
    end
  end

  assign bus.wb_hold    = wb_hold_q;
  assign bus.err_sticky = err_q;

endmodule

// File: tb/tb_reg_wport_sched.sv
// Bench for reg_wport_sched: reset checks, a directed vector table, hand
// sequences for starvation/err_sticky/mid-run reset, then random traffic
// compared against a behavioural model.
module tb_reg_wport_sched;
  import reg_wport_sched_pkg::*;

  localparam int unsigned SMAX = 4;

  typedef struct {
    logic      wb_we;
    reg_addr_t wb_waddr;
    reg_data_t wb_wdata;
    logic      lu_valid;
    reg_addr_t lu_waddr;
    reg_data_t lu_wdata;
    logic      is_valid;
    logic      is_long;
    reg_addr_t is_rs;
    logic      is_rs_re;
    reg_addr_t is_rt;
    logic      is_rt_re;
    reg_addr_t is_rd;
    logic      is_rd_we;
  } stim_t;

  typedef struct {
    string       name;
    stim_t       s;
    logic        rf_we;
    reg_addr_t   rf_waddr;
    reg_data_t   rf_wdata;
    logic        lu_ready;
    logic        is_stall;
    logic [31:0] busy;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  reg_wport_sched_if bus ();

  reg_wport_sched #(.STARVE_MAX(SMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t s_wb(stim_t s, int a, int d);
    s.wb_we = 1'b1; s.wb_waddr = ADDR_W'(a); s.wb_wdata = DATA_W'(d);
    return s;
  endfunction

  function automatic stim_t s_lu(stim_t s, int a, int d);
    s.lu_valid = 1'b1; s.lu_waddr = ADDR_W'(a); s.lu_wdata = DATA_W'(d);
    return s;
  endfunction

  function automatic stim_t s_long(stim_t s, int rd);
    s.is_valid = 1'b1; s.is_long = 1'b1; s.is_rd = ADDR_W'(rd); s.is_rd_we = 1'b1;
    return s;
  endfunction

  function automatic stim_t s_rs(stim_t s, int rs);
    s.is_valid = 1'b1; s.is_rs = ADDR_W'(rs); s.is_rs_re = 1'b1;
    return s;
  endfunction

  function automatic stim_t s_rt(stim_t s, int rt, logic re);
    s.is_valid = 1'b1; s.is_rt = ADDR_W'(rt); s.is_rt_re = re;
    return s;
  endfunction

  function automatic vec_t mk(string n, stim_t s, logic we, int a, int d,
                              logic lr, logic st, logic [31:0] b);
    vec_t v;
    v.name = n; v.s = s; v.rf_we = we; v.rf_waddr = ADDR_W'(a);
    v.rf_wdata = DATA_W'(d); v.lu_ready = lr; v.is_stall = st; v.busy = b;
    return v;
  endfunction

  task automatic drive(input stim_t s);
    bus.wb_we    = s.wb_we;    bus.wb_waddr = s.wb_waddr; bus.wb_wdata = s.wb_wdata;
    bus.lu_valid = s.lu_valid; bus.lu_waddr = s.lu_waddr; bus.lu_wdata = s.lu_wdata;
    bus.is_valid = s.is_valid; bus.is_long  = s.is_long;
    bus.is_rs    = s.is_rs;    bus.is_rs_re = s.is_rs_re;
    bus.is_rt    = s.is_rt;    bus.is_rt_re = s.is_rt_re;
    bus.is_rd    = s.is_rd;    bus.is_rd_we = s.is_rd_we;
  endtask

  // Drive just after the edge, sample on the falling edge.
  task automatic cyc(input stim_t s);
    @(posedge clk);
    #1 drive(s);
    @(negedge clk);
  endtask

  vec_t tbl[$];

  // behavioural model state for the random phase
  logic [31:0] mbusy;
  int          run_len;
  logic        mhold;
  logic        merr;
  logic        lu_pend;
  reg_addr_t   lu_a;
  reg_data_t   lu_d;

  initial begin
    stim_t s;
    total = 0;
    bad   = 0;

    // ---------------- reset held with live requests ----------------
    rst = 1'b0;
    drive(s_lu(s_rs(s_wb(idle(), 5, 32'h1), 1), 6, 32'h2));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
      chk("rst_lu_ready", 32'(bus.lu_ready), 32'd0);
      chk("rst_is_stall", 32'(bus.is_stall), 32'd1);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    drive(idle());
    @(negedge clk);
    chk("rst_busy", bus.busy_vec, 32'd0);
    chk("rst_err", 32'(bus.err_sticky), 32'd0);
    chk("rst_hold", 32'(bus.wb_hold), 32'd0);
    chk("rst_idle_stall", 32'(bus.is_stall), 32'd0);

    // ---------------- directed table (expectations = same cycle) ----------------
    tbl.push_back(mk("wb_w5",      s_wb(idle(), 5, 32'h1234),              1, 5, 32'h1234, 0, 0, 32'h0));
    tbl.push_back(mk("lu_r0",      s_lu(idle(), 0, 32'hdead),              0, 0, 32'hdead, 1, 0, 32'h0));
    tbl.push_back(mk("issue_r8",   s_long(idle(), 8),                      0, 0, 0,        0, 0, 32'h0));
    tbl.push_back(mk("raw_rs8",    s_rs(idle(), 8),                        0, 0, 0,        0, 1, 32'h100));
    tbl.push_back(mk("raw_rt8",    s_rt(idle(), 8, 1),                     0, 0, 0,        0, 1, 32'h100));
    tbl.push_back(mk("rt8_nore",   s_rt(idle(), 8, 0),                     0, 0, 0,        0, 0, 32'h100));
    tbl.push_back(mk("clr8_stall", s_lu(s_rs(idle(), 8), 8, 32'h55),       1, 8, 32'h55,   1, 1, 32'h100));
    tbl.push_back(mk("rs8_free",   s_rs(idle(), 8),                        0, 0, 0,        0, 0, 32'h0));
    tbl.push_back(mk("contend",    s_lu(s_wb(idle(), 2, 32'haaaa), 9, 32'h99), 1, 2, 32'haaaa, 0, 0, 32'h0));
    tbl.push_back(mk("lu_after",   s_lu(idle(), 9, 32'h99),                1, 9, 32'h99,   1, 0, 32'h0));
    tbl.push_back(mk("issue_r3",   s_long(idle(), 3),                      0, 0, 0,        0, 0, 32'h0));
    tbl.push_back(mk("waw_r3",     s_long(idle(), 3),                      0, 0, 0,        0, 1, 32'h8));
    tbl.push_back(mk("waw_clr3",   s_lu(s_long(idle(), 3), 3, 32'h33),     1, 3, 32'h33,   1, 1, 32'h8));
    tbl.push_back(mk("waw_go",     s_long(idle(), 3),                      0, 0, 0,        0, 0, 32'h0));
    tbl.push_back(mk("r3_busy",    idle(),                                 0, 0, 0,        0, 0, 32'h8));
    tbl.push_back(mk("clr3",       s_lu(idle(), 3, 32'h34),                1, 3, 32'h34,   1, 0, 32'h8));
    tbl.push_back(mk("r3_free",    idle(),                                 0, 0, 0,        0, 0, 32'h0));
    tbl.push_back(mk("long_blk",   s_long(s_lu(s_wb(idle(), 1, 1), 7, 32'h77), 10), 1, 1, 1, 0, 1, 32'h0));
    tbl.push_back(mk("long_ok",    s_long(s_lu(idle(), 7, 32'h77), 10),    1, 7, 32'h77,   1, 0, 32'h0));
    tbl.push_back(mk("r10_busy",   idle(),                                 0, 0, 0,        0, 0, 32'h400));
    tbl.push_back(mk("clrA_setB",  s_long(s_lu(idle(), 10, 32'ha0), 11),  1, 10, 32'ha0,  1, 0, 32'h400));
    tbl.push_back(mk("r11_busy",   idle(),                                 0, 0, 0,        0, 0, 32'h800));
    tbl.push_back(mk("clr11",      s_lu(idle(), 11, 32'hb0),               1, 11, 32'hb0,  1, 0, 32'h800));
    tbl.push_back(mk("all_idle",   idle(),                                 0, 0, 0,        0, 0, 32'h0));

    foreach (tbl[i]) begin
      cyc(tbl[i].s);
      chk({tbl[i].name, ".rf_we"},    32'(bus.rf_we),    32'(tbl[i].rf_we));
      chk({tbl[i].name, ".rf_waddr"}, 32'(bus.rf_waddr), 32'(tbl[i].rf_waddr));
      chk({tbl[i].name, ".rf_wdata"}, bus.rf_wdata,      tbl[i].rf_wdata);
      chk({tbl[i].name, ".lu_ready"}, 32'(bus.lu_ready), 32'(tbl[i].lu_ready));
      chk({tbl[i].name, ".is_stall"}, 32'(bus.is_stall), 32'(tbl[i].is_stall));
      chk({tbl[i].name, ".wb_hold"},  32'(bus.wb_hold),  32'd0);
      chk({tbl[i].name, ".busy"},     bus.busy_vec,      tbl[i].busy);
    end

    // ---------------- starvation, pipeline honours the bubble ----------------
    for (int k = 0; k < 4; k++) begin
      cyc(s_lu(s_wb(idle(), 4, k), 12, 32'hc0));
      chk("starveA_hold0", 32'(bus.wb_hold), 32'd0);
      chk("starveA_lr0", 32'(bus.lu_ready), 32'd0);
    end
    cyc(s_lu(idle(), 12, 32'hc0));
    chk("starveA_hold5", 32'(bus.wb_hold), 32'd1);
    chk("starveA_lr5", 32'(bus.lu_ready), 32'd1);
    chk("starveA_addr5", 32'(bus.rf_waddr), 32'd12);
    chk("starveA_data5", bus.rf_wdata, 32'hc0);
    cyc(idle());
    chk("starveA_hold6", 32'(bus.wb_hold), 32'd0);
    chk("starveA_err", 32'(bus.err_sticky), 32'd0);

    // ---------------- starvation, WB ignores the bubble ----------------
    for (int k = 0; k < 4; k++) cyc(s_lu(s_wb(idle(), 4, k), 13, 32'hd0));
    cyc(s_lu(s_wb(idle(), 4, 9), 13, 32'hd0));
    chk("starveB_hold5", 32'(bus.wb_hold), 32'd1);
    chk("starveB_lr5", 32'(bus.lu_ready), 32'd0);
    chk("starveB_addr5", 32'(bus.rf_waddr), 32'd4);
    chk("starveB_err_pre", 32'(bus.err_sticky), 32'd0);
    cyc(s_lu(idle(), 13, 32'hd0));
    chk("starveB_hold6", 32'(bus.wb_hold), 32'd0);
    chk("starveB_lr6", 32'(bus.lu_ready), 32'd1);
    chk("starveB_err6", 32'(bus.err_sticky), 32'd1);
    cyc(idle());
    chk("starveB_err7", 32'(bus.err_sticky), 32'd1);

    // ---------------- reset mid-operation discards busy and err ----------------
    cyc(s_long(idle(), 20));
    cyc(idle());
    chk("mid_busy20", bus.busy_vec, 32'h0010_0000);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", bus.busy_vec, 32'd0);
    chk("mid_rst_err", 32'(bus.err_sticky), 32'd0);

    // ---------------- random traffic vs behavioural model ----------------
    mbusy = '0; run_len = 0; mhold = 1'b0; merr = 1'b0; lu_pend = 1'b0;
    lu_a = '0; lu_d = '0;
    for (int c = 0; c < 3000; c++) begin
      logic      r;
      logic      e_lr;
      logic      e_req;
      logic      e_st;
      reg_addr_t e_a;
      reg_data_t e_d;
      int        q[$];
      s = idle();
      r = ($urandom_range(0, 249) != 0);
      // the long unit only ever returns results for registers it owes
      if (!lu_pend && mbusy != 0 && $urandom_range(0, 2) == 0) begin
        for (int i = 0; i < 32; i++) if (mbusy[i]) q.push_back(i);
        lu_a    = ADDR_W'(q[$urandom_range(0, q.size() - 1)]);
        lu_d    = DATA_W'($urandom);
        lu_pend = 1'b1;
      end
      s.lu_valid = lu_pend; s.lu_waddr = lu_a; s.lu_wdata = lu_d;
      s.wb_we    = ($urandom_range(0, 3) != 0);
      if (mhold && $urandom_range(0, 7) != 0) s.wb_we = 1'b0;
      s.wb_waddr = ADDR_W'($urandom);
      s.wb_wdata = DATA_W'($urandom);
      s.is_valid = ($urandom_range(0, 3) != 0);
      s.is_long  = 1'($urandom_range(0, 1));
      s.is_rs    = ADDR_W'($urandom_range(0, 15));
      s.is_rt    = ADDR_W'($urandom_range(0, 15));
      s.is_rd    = ADDR_W'($urandom_range(0, 15));
      s.is_rs_re = 1'($urandom_range(0, 1));
      s.is_rt_re = 1'($urandom_range(0, 1));
      s.is_rd_we = 1'($urandom_range(0, 1));

      @(posedge clk);
      #1 rst = r;
      drive(s);
      @(negedge clk);

      e_lr  = r && !s.wb_we && s.lu_valid;
      e_req = r && (s.wb_we || s.lu_valid);
      e_a   = s.wb_we ? s.wb_waddr : (s.lu_valid ? s.lu_waddr : '0);
      e_d   = s.wb_we ? s.wb_wdata : (s.lu_valid ? s.lu_wdata : '0);
      e_st  = !r || (s.is_valid && ((s.is_rs_re && mbusy[s.is_rs]) ||
                                    (s.is_rt_re && mbusy[s.is_rt]) ||
                                    (s.is_rd_we && mbusy[s.is_rd]) ||
                                    (s.is_long && s.lu_valid && !e_lr)));

      chk("rnd_rf_we", 32'(bus.rf_we), 32'(e_req && e_a != 0));
      chk("rnd_lu_ready", 32'(bus.lu_ready), 32'(e_lr));
      chk("rnd_is_stall", 32'(bus.is_stall), 32'(e_st));
      if (r) begin
        chk("rnd_rf_waddr", 32'(bus.rf_waddr), 32'(e_a));
        chk("rnd_rf_wdata", bus.rf_wdata, e_d);
      end
      chk("rnd_busy", bus.busy_vec, mbusy);
      chk("rnd_hold", 32'(bus.wb_hold), 32'(mhold));
      chk("rnd_err", 32'(bus.err_sticky), 32'(merr));

      // state after the coming edge
      if (!r) begin
        mbusy = '0; run_len = 0; mhold = 1'b0; merr = 1'b0; lu_pend = 1'b0;
      end else begin
        if (mhold && s.wb_we) merr = 1'b1;
        if (e_lr) begin
          mbusy[lu_a] = 1'b0;
          lu_pend     = 1'b0;
        end
        if (s.is_valid && s.is_long && s.is_rd_we && !e_st && s.is_rd != 0)
          mbusy[s.is_rd] = 1'b1;
        // a bubble is owed after every SMAX-th consecutive blocked cycle
        if (s.lu_valid && !e_lr) begin
          run_len++;
          mhold = ((run_len % SMAX) == 0);
        end else begin
          run_len = 0;
          mhold   = 1'b0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
